// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI4 read master (AR/R) between NUM_REQ load engines.
// Round-robin arbitration and one outstanding burst. A grant is held from AR
// acceptance until the RLAST handshake. R beats route only to the granted requester.
//
// Ports
//   clk, rst           clock (rising edge) and asynchronous active-low reset
//   req_ar*            per-requester AR address, length and valid; one-hot arready
//   req_r*             broadcast RDATA/RRESP/RLAST, one-hot rvalid, per-requester rready
//   m_AR*, m_R*        AXI4 read master AR/R channels
//   busy               arbiter is not IDLE
//   grant_id           current or most recent grant index
//   err / err_clr      sticky errors {RRESP != OKAY, beat-count/RLAST mismatch}; sync clear
module axi_rd_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 4,
  parameter int unsigned SIZE_WIDTH = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_araddr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_arlen,
  input  logic [NUM_REQ-1:0]              req_arvalid,
  output logic [NUM_REQ-1:0]              req_arready,
  output logic [STRB_WIDTH*8-1:0]         req_rdata,
  output logic [1:0]                      req_rresp,
  output logic                            req_rlast,
  output logic [NUM_REQ-1:0]              req_rvalid,
  input  logic [NUM_REQ-1:0]              req_rready,
  output logic [ADDR_WIDTH-1:0]           m_ARADDR,
  output logic [LEN_WIDTH-1:0]            m_ARLEN,
  output logic [SIZE_WIDTH-1:0]           m_ARSIZE,
  output logic [1:0]                      m_ARBURST,
  output logic                            m_ARVALID,
  input  logic                            m_ARREADY,
  input  logic [STRB_WIDTH*8-1:0]         m_RDATA,
  input  logic [1:0]                      m_RRESP,
  input  logic                            m_RLAST,
  input  logic                            m_RVALID,
  output logic                            m_RREADY,
  output logic                            busy,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic [1:0]                      err,
  input  logic                            err_clr
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t                 r_state;
  logic [ID_W-1:0]        r_grant;
  logic [ID_W-1:0]        r_rr_ptr;
  logic [ADDR_WIDTH-1:0]  r_araddr;
  logic [LEN_WIDTH-1:0]   r_arlen;
  logic [LEN_WIDTH-1:0]   r_beat_cnt;
  logic                   r_arvalid;
  logic [1:0]             r_err;

  logic [ID_W-1:0]        w_winner;
  logic                   w_any;
  logic                   w_idle;
  logic                   w_data;
  logic                   w_rready_sel;
  logic                   w_fire;
  logic [1:0]             w_err_set;
  logic [ID_W-1:0]        w_next_ptr;
  logic [NUM_REQ-1:0]     w_arready;
  logic [NUM_REQ-1:0]     w_rvalid;

  // Round-robin pick: first valid requester at or after r_rr_ptr, cyclically.
  always_comb begin
    int unsigned idx;
    w_winner = '0;
    w_any    = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_any && req_arvalid[idx]) begin
        w_winner = ID_W'(idx);
        w_any    = 1'b1;
      end
    end
  end

  // Reset is folded in so arready stays low while the arbiter is held in reset.
  assign w_idle       = (r_state == S_IDLE) && rst;
  assign w_data       = (r_state == S_DATA);
  assign w_rready_sel = req_rready[r_grant];
  assign w_fire       = w_data && m_RVALID && w_rready_sel;

  // Early RLAST, or a non-final beat at/after the expected count, flags a length mismatch.
  assign w_err_set[0] = w_fire && (m_RLAST ? (r_beat_cnt != r_arlen) : (r_beat_cnt >= r_arlen));
  assign w_err_set[1] = w_fire && (m_RRESP != 2'b00);

  assign w_next_ptr = (r_grant == ID_W'(NUM_REQ - 1)) ? '0 : r_grant + ID_W'(1);

  // One-hot AR acceptance and R routing to the granted requester.
  always_comb begin
    w_arready = '0;
    w_rvalid  = '0;
    w_arready[w_winner] = w_idle && w_any;
    w_rvalid[r_grant]   = w_data && m_RVALID;
  end

  // Arbitration state, latched AR payload, beat counter and sticky errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_araddr   <= '0;
      r_arlen    <= '0;
      r_beat_cnt <= '0;
      r_arvalid  <= 1'b0;
      r_err      <= '0;
    end else begin
      if (err_clr) begin
        r_err <= '0;
      end else begin
        r_err <= r_err | w_err_set;
      end

      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_araddr   <= req_araddr[32'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
            r_arlen    <= req_arlen[32'(w_winner)*LEN_WIDTH +: LEN_WIDTH];
            r_grant    <= w_winner;
            r_beat_cnt <= '0;
            r_arvalid  <= 1'b1;
            r_state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (m_ARREADY) begin
            r_arvalid <= 1'b0;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_fire) begin
            if (r_beat_cnt != '1) begin
              r_beat_cnt <= r_beat_cnt + LEN_WIDTH'(1);
            end
            if (m_RLAST) begin
              r_rr_ptr <= w_next_ptr;
              r_state  <= S_IDLE;
            end
          end
        end
        default: begin
          r_arvalid <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign req_arready = w_arready;
  assign req_rvalid  = w_rvalid;
  assign req_rdata   = m_RDATA;
  assign req_rresp   = m_RRESP;
  assign req_rlast   = m_RLAST;
  assign m_RREADY    = w_data && w_rready_sel;
  assign m_ARADDR    = r_araddr;
  assign m_ARLEN     = r_arlen;
  assign m_ARSIZE    = SIZE_WIDTH'($clog2(STRB_WIDTH));
  assign m_ARBURST   = 2'b01;
  assign m_ARVALID   = r_arvalid;
  assign busy        = (r_state != S_IDLE);
  assign grant_id    = r_grant;
  assign err         = r_err;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: routing, round-robin order, backpressure,
// length/response errors and mid-burst reset.
module tb_axi_rd_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = 8;
  localparam int unsigned LW = 4;
  localparam int unsigned ZW = 3;
  localparam int unsigned DW = SW * 8;

  logic              clk;
  logic              rst;
  logic [NR*AW-1:0]  req_araddr;
  logic [NR*LW-1:0]  req_arlen;
  logic [NR-1:0]     req_arvalid;
  logic [NR-1:0]     req_arready;
  logic [DW-1:0]     req_rdata;
  logic [1:0]        req_rresp;
  logic              req_rlast;
  logic [NR-1:0]     req_rvalid;
  logic [NR-1:0]     req_rready;
  logic [AW-1:0]     m_ARADDR;
  logic [LW-1:0]     m_ARLEN;
  logic [ZW-1:0]     m_ARSIZE;
  logic [1:0]        m_ARBURST;
  logic              m_ARVALID;
  logic              m_ARREADY;
  logic [DW-1:0]     m_RDATA;
  logic [1:0]        m_RRESP;
  logic              m_RLAST;
  logic              m_RVALID;
  logic              m_RREADY;
  logic              busy;
  logic [1:0]        grant_id;
  logic [1:0]        err;
  logic              err_clr;

  int n_assert = 0;
  int n_fail   = 0;

  axi_rd_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .LEN_WIDTH(LW), .SIZE_WIDTH(ZW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_araddr(req_araddr), .req_arlen(req_arlen), .req_arvalid(req_arvalid),
    .req_arready(req_arready), .req_rdata(req_rdata), .req_rresp(req_rresp),
    .req_rlast(req_rlast), .req_rvalid(req_rvalid), .req_rready(req_rready),
    .m_ARADDR(m_ARADDR), .m_ARLEN(m_ARLEN), .m_ARSIZE(m_ARSIZE), .m_ARBURST(m_ARBURST),
    .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP),
    .m_RLAST(m_RLAST), .m_RVALID(m_RVALID), .m_RREADY(m_RREADY),
    .busy(busy), .grant_id(grant_id), .err(err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $error("FAIL watchdog: observed no end of test, expected finish before 500us");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present vld, check the one-hot winner, then complete the AR handshake.
  task automatic grant(input logic [NR-1:0] vld, input int exp_id,
                       input logic [AW-1:0] addr, input logic [LW-1:0] len);
    for (int i = 0; i < int'(NR); i++) begin
      req_araddr[i*AW +: AW] = addr;
      req_arlen[i*LW +: LW]  = len;
    end
    req_arvalid = vld;
    #1;
    chk("arready", 64'(req_arready), 64'(1) << exp_id);
    step();
    req_arvalid = '0;
    #1;
    chk("arvalid", 64'(m_ARVALID), 64'd1);
    chk("grant_id", 64'(grant_id), 64'(exp_id));
    chk("araddr", 64'(m_ARADDR), 64'(addr));
    chk("arlen", 64'(m_ARLEN), 64'(len));
    m_ARREADY = 1'b1;
    step();
    m_ARREADY = 1'b0;
  endtask

  // One R beat accepted by every requester; checks routing and broadcast data.
  task automatic beat(input int gid, input logic [DW-1:0] data, input logic last,
                      input logic [1:0] resp);
    m_RVALID   = 1'b1;
    m_RDATA    = data;
    m_RLAST    = last;
    m_RRESP    = resp;
    req_rready = '1;
    #1;
    chk("rvalid", 64'(req_rvalid), 64'(1) << gid);
    chk("rdata", 64'(req_rdata), 64'(data));
    chk("rready", 64'(m_RREADY), 64'd1);
    step();
    m_RVALID = 1'b0;
    m_RLAST  = 1'b0;
    m_RRESP  = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b0;
    req_araddr = '0; req_arlen = '0; req_arvalid = '0; req_rready = '0;
    m_ARREADY = 1'b0; m_RDATA = '0; m_RRESP = 2'b00; m_RLAST = 1'b0; m_RVALID = 1'b0;
    err_clr = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_arvalid", 64'(m_ARVALID), 64'd0);
    chk("rst_rready", 64'(m_RREADY), 64'd0);
    chk("rst_arready", 64'(req_arready), 64'd0);
    chk("rst_rvalid", 64'(req_rvalid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_araddr", 64'(m_ARADDR), 64'd0);
    chk("rst_arlen", 64'(m_ARLEN), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    step();

    // 1: requester 2, addr 0x1000, len 3
    grant(4'b0100, 2, 32'h0000_1000, 4'd3);
    chk("t1_arsize", 64'(m_ARSIZE), 64'd3);
    chk("t1_arburst", 64'(m_ARBURST), 64'd1);
    chk("t1_arvalid_off", 64'(m_ARVALID), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    for (int b = 0; b < 4; b++) beat(2, 64'hA0A0_0000_0000_0000 | 64'(b), b == 3, 2'b00);
    chk("t1_busy_after", 64'(busy), 64'd0);
    chk("t1_rvalid_after", 64'(req_rvalid), 64'd0);
    chk("t1_err", 64'(err), 64'd0);

    // 2: round-robin order 0,1,2,3,0 then 3,0 with only 0 and 3 asking
    do_reset();
    grant(4'b1111, 0, 32'h0000_2000, 4'd0); beat(0, 64'h20, 1'b1, 2'b00);
    grant(4'b1111, 1, 32'h0000_2000, 4'd0); beat(1, 64'h21, 1'b1, 2'b00);
    grant(4'b1111, 2, 32'h0000_2000, 4'd0); beat(2, 64'h22, 1'b1, 2'b00);
    grant(4'b1111, 3, 32'h0000_2000, 4'd0); beat(3, 64'h23, 1'b1, 2'b00);
    grant(4'b1111, 0, 32'h0000_2000, 4'd0); beat(0, 64'h24, 1'b1, 2'b00);
    grant(4'b1001, 3, 32'h0000_2100, 4'd0); beat(3, 64'h25, 1'b1, 2'b00);
    grant(4'b1001, 0, 32'h0000_2100, 4'd0); beat(0, 64'h26, 1'b1, 2'b00);
    chk("t2_err", 64'(err), 64'd0);

    // 3: len 7 with a 3-cycle rready stall at beat 2
    grant(4'b0010, 1, 32'h0000_3000, 4'd7);
    beat(1, 64'h30, 1'b0, 2'b00);
    beat(1, 64'h31, 1'b0, 2'b00);
    for (int s = 0; s < 3; s++) begin
      m_RVALID = 1'b1; m_RDATA = 64'h32; req_rready = '0;
      #1;
      chk("t3_stall_rready", 64'(m_RREADY), 64'd0);
      chk("t3_stall_rvalid", 64'(req_rvalid), 64'b0010);
      step();
    end
    for (int b = 2; b < 8; b++) beat(1, 64'h30 + 64'(b), b == 7, 2'b00);
    chk("t3_err", 64'(err), 64'd0);
    chk("t3_busy", 64'(busy), 64'd0);

    // 4a: len 3, RLAST early on beat 2
    grant(4'b0001, 0, 32'h0000_4000, 4'd3);
    beat(0, 64'h40, 1'b0, 2'b00);
    beat(0, 64'h41, 1'b0, 2'b00);
    beat(0, 64'h42, 1'b1, 2'b00);
    chk("t4a_err", 64'(err), 64'b01);
    chk("t4a_busy", 64'(busy), 64'd0);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("t4a_clr", 64'(err), 64'd0);

    // 4b: len 1, RLAST only on beat 2 (third beat)
    grant(4'b1000, 3, 32'h0000_4100, 4'd1);
    beat(3, 64'h43, 1'b0, 2'b00);
    chk("t4b_err_mid", 64'(err), 64'd0);
    beat(3, 64'h44, 1'b0, 2'b00);
    chk("t4b_err_over", 64'(err), 64'b01);
    chk("t4b_busy_mid", 64'(busy), 64'd1);
    beat(3, 64'h45, 1'b1, 2'b00);
    chk("t4b_busy", 64'(busy), 64'd0);
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // 5: SLVERR on beat 0, sticky until err_clr
    grant(4'b0100, 2, 32'h0000_5000, 4'd1);
    beat(2, 64'h50, 1'b0, 2'b10);
    chk("t5_err_set", 64'(err), 64'b10);
    beat(2, 64'h51, 1'b1, 2'b00);
    step();
    chk("t5_err_held", 64'(err), 64'b10);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("t5_err_clr", 64'(err), 64'd0);

    // 6: async reset in the middle of a burst
    grant(4'b0010, 1, 32'h0000_6000, 4'd3);
    beat(1, 64'h60, 1'b0, 2'b00);
    m_RVALID = 1'b1; m_RDATA = 64'h61; req_rready = '1;
    #1;
    chk("t6_pre_rvalid", 64'(req_rvalid), 64'b0010);
    rst = 1'b0;
    #1;
    chk("t6_rst_rready", 64'(m_RREADY), 64'd0);
    chk("t6_rst_rvalid", 64'(req_rvalid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    m_RVALID = 1'b0;
    step();
    rst = 1'b1;
    step();
    grant(4'b1111, 0, 32'h0000_6100, 4'd0);
    beat(0, 64'h62, 1'b1, 2'b00);
    chk("t6_busy_end", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
